// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use bubble, MDU busy interlock, and branch flush, plus stall/flush counters.
// Control outputs are combinational from inputs and MDU count; stalls hold PC and IF/ID while ID/EX takes a bubble.
module pipe_hazard_ctrl #(
  parameter int MDU_CYCLES = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        mdu_start,
  input  logic        mdu_read,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        mdu_go,
  output logic        mdu_busy,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  localparam logic [5:0] CNT_LOAD = 6'(MDU_CYCLES);

  logic [5:0] cnt;
  logic       lu_hazard;
  logic       mdu_hazard;
  logic       sel_flush;
  logic       sel_stall;

  assign lu_hazard  = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign mdu_busy   = (cnt != 6'd0);
  assign mdu_hazard = (mdu_start || mdu_read) && mdu_busy;

  // Reset forces the run-state view so the front end keeps fetching cleanly.
  assign sel_flush = !Rst && branch_taken;
  assign sel_stall = !Rst && !branch_taken && (lu_hazard || mdu_hazard);

  assign pc_write   = !sel_stall;
  assign ifid_write = !sel_stall;
  assign ifid_flush = sel_flush;
  assign idex_flush = sel_flush || sel_stall;
  // A stalled mult/div relaunches here on the first run cycle after cnt hits zero.
  assign mdu_go     = !Rst && !branch_taken && !lu_hazard && !mdu_hazard && mdu_start;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt         <= 6'd0;
      stall_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (mdu_go)
        cnt <= CNT_LOAD;
      else if (cnt != 6'd0)
        cnt <= cnt - 6'd1;

      if (sel_stall && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;

      if (sel_flush && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_CYCLES, default 32, meaning multiply/divide unit latency in cycles; legal range 2..63.
REQ-002 SHALL have port Clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port id_rs  input  5  rs register index of the instruction in ID.
REQ-005 SHALL have port id_rt  input  5  rt register index of the instruction in ID.
REQ-006 SHALL have port id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-007 SHALL have port ex_mem_read  input  1  EX instruction is a load.
REQ-008 SHALL have port ex_rt  input  5  destination register of the load in EX.
REQ-009 SHALL have port branch_taken  input  1  taken branch/jump resolved in EX this cycle.
REQ-010 SHALL have port mdu_start  input  1  ID instruction issues a mult/div.
REQ-011 SHALL have port mdu_read  input  1  ID instruction reads HI/LO (mfhi/mflo).
REQ-012 SHALL have port pc_write  output  1  PC register load enable.
REQ-013 SHALL have port ifid_write  output  1  IF/ID pipeline register load enable.
REQ-014 SHALL have port ifid_flush  output  1  IF/ID pipeline register synchronous clear.
REQ-015 SHALL have port idex_flush  output  1  ID/EX clear (insert bubble).
REQ-016 SHALL have port mdu_go  output  1  one-cycle pulse launching the MDU.
REQ-017 SHALL have port mdu_busy  output  1  MDU operation in flight.
REQ-018 SHALL have port stall_count  output  32  cycles in which a stall was asserted.
REQ-019 SHALL have port flush_count  output  32  cycles in which branch_taken caused a flush.

Function
REQ-020 SHALL compute lu_hazard = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)), combinationally.
REQ-021 SHALL hold 6-bit counter cnt; mdu_busy = (cnt!=0).
REQ-022 SHALL compute mdu_hazard = (mdu_start || mdu_read) && cnt!=0.
REQ-023 SHALL apply priority flush > lu_hazard > mdu_hazard > run, evaluated each cycle, outputs combinational from inputs and cnt.
REQ-024 SHALL, flush (branch_taken=1): pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, mdu_go=0, regardless of any hazard.
REQ-025 SHALL, lu_hazard: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1; exactly one bubble per occurrence (hazard clears once load leaves EX).
REQ-026 SHALL, mdu_hazard: pc_write=0, ifid_write=0, idex_flush=1, held every cycle until cnt==0.
REQ-027 SHALL, run: pc_write=1, ifid_write=1, both flushes 0.
REQ-028 SHALL assert mdu_go only in run with mdu_start=1 (cnt==0); next edge cnt <= MDU_CYCLES.
REQ-029 SHALL decrement cnt by 1 each edge while cnt!=0 and no new launch; cnt never wraps below 0.
REQ-030 SHALL, a stalled mdu_start launch in the first run cycle after cnt reaches 0 (no lost or duplicated launch).
REQ-031 SHALL not launch mdu_start coincident with branch_taken (ID instruction squashed); an in-flight operation continues counting.
REQ-032 SHALL increment stall_count on edges where lu_hazard or mdu_hazard selected; saturate at 0xFFFFFFFF.
REQ-033 SHALL increment flush_count on edges where branch_taken=1; saturate at 0xFFFFFFFF.

Reset
REQ-034 SHALL, on Rst=1, immediately clear cnt, stall_count, flush_count to 0 independent of Clk.
REQ-035 SHALL, during reset, drive pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0, mdu_go=0, mdu_busy=0.
REQ-036 SHALL abort an in-flight MDU count on reset mid-operation; no mdu_go on release.

Verification
REQ-037 SHALL test load-use: ex_mem_read=1, ex_rt=8, id_rs=8 for 1 cycle -> pc_write=0, ifid_write=0, idex_flush=1 that cycle, stall_count=1.
REQ-038 SHALL test $zero: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall, pc_write=1.
REQ-039 SHALL test MDU: MDU_CYCLES=4, mdu_start in run -> mdu_go pulse, mdu_busy 4 cycles; mdu_read next cycle -> 4 stall cycles then release, stall_count=4.
REQ-040 SHALL test back-to-back: second mdu_start while busy -> stalled, mdu_go exactly once when cnt==0, cnt reloads 4.
REQ-041 SHALL test collision: branch_taken with lu_hazard and mdu_start same cycle -> both flushes 1, pc_write=1, mdu_go=0, flush_count=1, stall_count unchanged.
REQ-042 SHALL test reset: Rst asserted at cnt=2 between edges -> mdu_busy=0 immediately, counters 0, no mdu_go after release.
